// File: rtl/fixed_mul_seq.sv
// Sequential signed fixed-point multiplier, Q(INT_WID.RAT_WID) operands and result.
// Operands are accepted in IDLE as magnitude + sign, multiplied one bit per cycle
// with a right-shifting shift-add accumulator, then rescaled, signed and saturated.
module fixed_mul_seq #(
    parameter int INT_WID = 10,
    parameter int RAT_WID = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INT_WID+RAT_WID-1:0]   a,
    input  logic [INT_WID+RAT_WID-1:0]   b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INT_WID+RAT_WID-1:0]   p,
    output logic                         ovf
);

    localparam int W  = INT_WID + RAT_WID;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0]  LAST_BIT = CW'(W - 1);
    // Largest positive magnitude and largest negative magnitude, in accumulator width
    localparam logic [2*W-1:0] POS_LIM  = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [2*W-1:0] NEG_LIM  = {{W{1'b0}}, 1'b1, {(W - 1){1'b0}}};
    localparam logic [W-1:0]   MAX_POS  = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]   MIN_NEG  = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [W-1:0]       mcand_reg;   // |a|
    logic [W-1:0]       mplier_reg;  // |b|, shifted right as bits are consumed
    logic               sign_reg;
    logic [2*W-1:0]     acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic [W-1:0]       p_reg;
    logic               ovf_reg;

    logic [W-1:0]       a_mag;
    logic [W-1:0]       b_mag;
    logic [W-1:0]       partial;
    logic [W:0]         sum;
    logic [2*W-1:0]     acc_shift;
    logic [2*W-1:0]     scaled;
    logic [W-1:0]       p_next;
    logic               ovf_next;

    // Operand magnitudes; the most negative value maps to 2^(W-1), which fits unsigned
    always_comb begin
        a_mag = a[W-1] ? (~a + W'(1)) : a;
        b_mag = b[W-1] ? (~b + W'(1)) : b;
    end

    // One shift-add step: add |a| into the upper half when the current multiplier bit is set
    always_comb begin
        partial   = mplier_reg[0] ? mcand_reg : '0;
        sum       = {1'b0, acc_reg[2*W-1:W]} + {1'b0, partial};
        acc_shift = {sum, acc_reg[W-1:1]};
    end

    // Rescale by truncating the magnitude, re-apply the sign and saturate
    always_comb begin
        scaled   = acc_reg >> RAT_WID;
        p_next   = scaled[W-1:0];
        ovf_next = 1'b0;
        if (!sign_reg) begin
            if (scaled > POS_LIM) begin
                p_next   = MAX_POS;
                ovf_next = 1'b1;
            end
        end else begin
            if (scaled > NEG_LIM) begin
                p_next   = MIN_NEG;
                ovf_next = 1'b1;
            end else begin
                // A zero magnitude negates to zero, so no negative-zero pattern arises
                p_next = ~scaled[W-1:0] + W'(1);
            end
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == LAST_BIT) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: capture in IDLE, accumulate in BUSY, load result in FIN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            sign_reg   <= 1'b0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            p_reg      <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mcand_reg  <= a_mag;
                        mplier_reg <= b_mag;
                        sign_reg   <= a[W-1] ^ b[W-1];
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                    end
                end
                BUSY: begin
                    acc_reg    <= acc_shift;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CW'(1);
                end
                FIN: begin
                    p_reg   <= p_next;
                    ovf_reg <= ovf_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign p   = p_reg;
    assign ovf = ovf_reg;

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Scoreboard bench for fixed_mul_seq: the driver pushes hand-computed results,
// an independent monitor pops and compares whenever a result is presented.
module tb_fixed_mul_seq;

    localparam int W       = 20;
    localparam int LATENCY = W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  p;
    logic          ovf;

    typedef struct {
        logic [W-1:0] p;
        logic         ovf;
        int           accept_cycle;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   seen   = 0;

    fixed_mul_seq #(.INT_WID(10), .RAT_WID(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: latency on first presentation, value check on handshake
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got p=%h ovf=%b with no pending operation", p, ovf);
            end else begin
                if (!seen) begin
                    check("latency", W'(cycle - sb[0].accept_cycle), W'(LATENCY));
                    seen = 1;
                end
                if (out_ready) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("p", p, e.p);
                    check("ovf", W'(ovf), W'(e.ovf));
                    $display("result p=%h ovf=%b (expected p=%h ovf=%b)", p, ovf, e.p, e.ovf);
                    seen = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for IDLE, present operands for one accepting edge, record expectation
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ep, input logic eo);
        exp_t e;
        int   n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=%b expected 1", in_ready);
            return;
        end
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        e.p      = ep;
        e.ovf    = eo;
        e.accept_cycle = cycle + 1;
        sb.push_back(e);
        $display("issue a=%h b=%h expect p=%h ovf=%b", va, vb, ep, eo);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got out_valid=%b expected 1", out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        tick();
        tick();
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_p", p, W'(0));
        check("reset_ovf", W'(ovf), W'(0));
        rst_n = 1'b1;
        tick();

        // Directed vectors with hand-computed results
        send(20'h00600, 20'h00800, 20'h00C00, 1'b0); //  1.5 *  2.0 =  3.0
        send(20'hFFA00, 20'h00800, 20'hFF400, 1'b0); // -1.5 *  2.0 = -3.0
        send(20'hFFA00, 20'hFF800, 20'h00C00, 1'b0); // -1.5 * -2.0 =  3.0
        send(20'h7FC00, 20'h01000, 20'h7FFFF, 1'b1); // 511 * 4 saturates high
        send(20'h80000, 20'h00400, 20'h80000, 1'b0); // -512 * 1 exactly representable
        send(20'h80000, 20'hFFC00, 20'h7FFFF, 1'b1); // -512 * -1 saturates high
        send(20'h80000, 20'h00800, 20'h80000, 1'b1); // -512 * 2 saturates low
        send(20'h00001, 20'h00001, 20'h00000, 1'b0); // underflow to zero
        send(20'hFFFFF, 20'h00001, 20'h00000, 1'b0); // negative underflow, no negative zero
        send(20'h00601, 20'h00800, 20'h00C02, 1'b0); // fractional bits carried
        send(20'hFFFFF, 20'h00600, 20'hFFFFF, 1'b0); // -1.5/1024 truncates toward zero
        send(20'h00C00, 20'hFF000, 20'hFD000, 1'b0); //  3.0 * -4.0 = -12.0

        // Back-pressure: result held while out_ready=0, operands during BUSY ignored
        while (in_ready !== 1'b1) tick();
        out_ready = 1'b0;
        send(20'h00600, 20'h00800, 20'h00C00, 1'b0);
        tick();
        a        = 20'h7FC00;
        b        = 20'h01000;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_p", p, 20'h00C00);
            check("stall_ovf", W'(ovf), W'(0));
            check("stall_out_valid", W'(out_valid), W'(1));
            check("stall_in_ready", W'(in_ready), W'(0));
        end
        // in_valid high across the DONE->IDLE edge must not start an operation
        a         = 20'h7FC00;
        b         = 20'h01000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        check("no_accept_on_return", W'(in_ready), W'(1));
        send(20'h00C00, 20'hFF000, 20'hFD000, 1'b0);

        // Reset in the middle of BUSY discards the operation
        while (in_ready !== 1'b1) tick();
        send(20'h7FC00, 20'h01000, 20'h7FFFF, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        check("mid_reset_in_ready", W'(in_ready), W'(1));
        check("mid_reset_out_valid", W'(out_valid), W'(0));
        check("mid_reset_p", p, W'(0));
        check("mid_reset_ovf", W'(ovf), W'(0));
        for (int i = 0; i < 30; i++) begin
            tick();
            check("post_reset_no_out", W'(out_valid), W'(0));
        end
        send(20'h00600, 20'h00800, 20'h00C00, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_mul_seq.md
FIXED_MUL_SEQ -- requirements
Module: fixed_mul_seq

Interface
REQ-001 SHALL have parameter INT_WID, default 10: integer bits of the signed two's-complement operand/result format.
REQ-002 SHALL have parameter RAT_WID, default 10: fractional bits; W = INT_WID+RAT_WID.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, sole clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operands a, b valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  W  multiplicand, signed Q(INT_WID.RAT_WID).
REQ-009 b  input  W  multiplier, signed Q(INT_WID.RAT_WID).
REQ-010 out_valid  output  1  p/ovf valid.
REQ-011 out_ready  input  1  downstream (rounding stage) accepts p.
REQ-012 p  output  W  product, signed Q(INT_WID.RAT_WID).
REQ-013 ovf  output  1  p was saturated.

Function
REQ-014 SHALL implement states IDLE, BUSY, FIN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: edge with in_valid=1 SHALL capture |a|, |b| into W-bit unsigned registers, sign = a[W-1] XOR b[W-1], clear 2W-bit accumulator and bit counter, and go to BUSY.
REQ-017 |x| of -2^(W-1) SHALL be 2^(W-1), held unsigned without loss.
REQ-018 BUSY: each edge SHALL process exactly one multiplier bit (shift-add), for exactly W edges, then go to FIN.
REQ-019 FIN: one edge SHALL form scaled = accumulator >> RAT_WID (truncation toward zero on magnitude), apply sign, saturate, load p/ovf, go to DONE.
REQ-020 Saturation: positive and scaled > 2^(W-1)-1 -> p = 2^(W-1)-1, ovf=1; negative and scaled > 2^(W-1) -> p = -2^(W-1), ovf=1; otherwise ovf=0.
REQ-021 A magnitude that truncates to zero SHALL yield p = 0 regardless of sign (no negative zero pattern, result 0).
REQ-022 Latency: out_valid SHALL rise after the (W+1)th edge following the accepting edge (21 edges at defaults).
REQ-023 DONE: p and ovf SHALL hold stable while out_ready=0; edge with out_ready=1 SHALL return to IDLE.
REQ-024 No acceptance SHALL occur on the DONE->IDLE edge; minimum initiation interval W+3 cycles.
REQ-025 in_valid, a, b SHALL be ignored outside IDLE; operand changes during BUSY SHALL not affect the result.
REQ-026 p and ovf SHALL retain last values in IDLE/BUSY/FIN (only FIN updates them).

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE, in_ready=1, out_valid=0, p=0, ovf=0, accumulator and counter=0.
REQ-028 Reset in BUSY, FIN or DONE SHALL discard the operation with no out_valid pulse.
REQ-029 rst_n=0 SHALL take priority over in_valid and out_ready on the same edge.

Verification (defaults W=20, RAT_WID=10)
REQ-030 a=0x00600 (1.5), b=0x00800 (2.0), out_ready=1 -> after 21 edges out_valid=1, p=0x00C00, ovf=0.
REQ-031 a=0xFFA00 (-1.5), b=0x00800 -> p=0xFF400 (-3.0), ovf=0; a=0xFFA00, b=0xFF800 -> p=0x00C00.
REQ-032 a=0x7FC00 (511.0), b=0x01000 (4.0) -> p=0x7FFFF, ovf=1; a=0x80000, b=0x00400 -> p=0x80000, ovf=0; a=0x80000, b=0xFFC00 -> p=0x7FFFF, ovf=1.
REQ-033 a=0x00001, b=0x00001 -> p=0x00000; a=0xFFFFF, b=0x00001 -> p=0x00000, ovf=0.
REQ-034 out_ready=0 for 5 cycles in DONE -> p, ovf, out_valid stable, in_ready=0; in_valid pulses with new operands during BUSY/DONE -> ignored, next result reflects only next IDLE acceptance.
REQ-035 rst_n=0 for one edge at BUSY cycle 7 -> next cycle IDLE, in_ready=1, p=0, ovf=0, no out_valid; subsequent accept of 1.5*2.0 -> p=0x00C00.
